// File: rtl/fir_band_filter.sv
// Single-rate FIR accumulator over one sequencing burst: multiplies each sample with its ROM
// coefficient and emits the Q1.15-scaled sum. Define FIR_SAT_EN to saturate instead of wrap.
module fir_band_filter #(
    parameter int unsigned TAPS = 1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sequencing,
    input  logic [15:0] smpl_in,
    output logic [9:0]  coef_addr,
    input  logic [15:0] coef,
    output logic [15:0] smpl_out,
    output logic        vld,
    output logic        len_err
);

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned SMPL_W = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned ACC_W  = 42;
    localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(TAPS);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_e;

    state_e                    state_q, state_d;
    logic                      seq_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic                      prod_vld_q, prod_vld_d;
    logic                      prod_first_q, prod_first_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [SMPL_W-1:0]         smpl_out_q, smpl_out_d;
    logic                      vld_q, vld_d;
    logic                      len_err_q, len_err_d;
    logic [CNT_W-1:0]          coef_addr_q, coef_addr_d;

    logic                      rise_c;
    logic                      accept_c;
    logic signed [SMPL_W-1:0]  smpl_s;
    logic signed [SMPL_W-1:0]  coef_s;
    logic signed [PROD_W-1:0]  mult_c;
    logic [SMPL_W-1:0]         scaled_c;

    assign rise_c = sequencing & ~seq_q;
    assign smpl_s = smpl_in;
    assign coef_s = coef;
    assign mult_c = PROD_W'(smpl_s) * PROD_W'(coef_s);

`ifdef FIR_SAT_EN
    logic ovr_c;
    // Bits above the Q1.15 window must all match the sign, otherwise clamp.
    assign ovr_c    = ~((&acc_q[ACC_W-1:30]) | ~(|acc_q[ACC_W-1:30]));
    assign scaled_c = ovr_c ? (acc_q[ACC_W-1] ? 16'h8000 : 16'h7FFF) : acc_q[30:15];
`else
    assign scaled_c = acc_q[30:15];
`endif

    // Next-state, tap counting and pipeline stages.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        accept_c     = 1'b0;
        prod_d       = prod_q;
        prod_vld_d   = 1'b0;
        prod_first_d = prod_first_q;
        acc_d        = acc_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                ovf_d = 1'b0;
                if (rise_c) begin
                    state_d  = ACCUM;
                    accept_c = 1'b1;
                end
            end
            ACCUM: begin
                if (!sequencing) begin
                    state_d = DRAIN;
                end else if (cnt_q < TAPS_C) begin
                    accept_c = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            cnt_d        = cnt_q + CNT_W'(1);
            prod_d       = mult_c;
            prod_vld_d   = 1'b1;
            prod_first_d = (state_q == IDLE);
        end

        if (prod_vld_q) begin
            acc_d = prod_first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
        end
    end

    // Registered outputs; the ROM address leads the sample by one cycle.
    always_comb begin
        vld_d       = (state_d == OUT);
        smpl_out_d  = vld_d ? scaled_c : smpl_out_q;
        len_err_d   = vld_d & ((cnt_q != TAPS_C) | ovf_q);
        coef_addr_d = (state_d == ACCUM) ? cnt_d + CNT_W'(1) : CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            seq_q        <= 1'b1;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
            acc_q        <= '0;
            smpl_out_q   <= '0;
            vld_q        <= 1'b0;
            len_err_q    <= 1'b0;
            coef_addr_q  <= CNT_W'(1);
        end else begin
            state_q      <= state_d;
            seq_q        <= sequencing;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            prod_q       <= prod_d;
            prod_vld_q   <= prod_vld_d;
            prod_first_q <= prod_first_d;
            acc_q        <= acc_d;
            smpl_out_q   <= smpl_out_d;
            vld_q        <= vld_d;
            len_err_q    <= len_err_d;
            coef_addr_q  <= coef_addr_d;
        end
    end

    assign coef_addr = coef_addr_q;
    assign smpl_out  = smpl_out_q;
    assign vld       = vld_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_fir_band_filter.sv
// Directed bench for fir_band_filter with a registered coefficient ROM model.
// ROM address 1 holds the first coefficient; expected sums are hand-computed.
module tb_fir_band_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sequencing;
    logic [15:0] smpl_in;
    logic [9:0]  coef_addr;
    logic [15:0] coef;
    logic [15:0] smpl_out;
    logic        vld;
    logic        len_err;

    logic [15:0] rom [0:1023];
    int n_vec = 0;
    int n_err = 0;

`ifdef FIR_SAT_EN
    localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
    localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
    localparam logic [15:0] EXP_POS_OVF = 16'h7806;
    localparam logic [15:0] EXP_NEG_OVF = 16'h83FD;
`endif

    fir_band_filter #(.TAPS(1021)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .smpl_in    (smpl_in),
        .coef_addr  (coef_addr),
        .coef       (coef),
        .smpl_out   (smpl_out),
        .vld        (vld),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) coef <= rom[coef_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rom(input logic [15:0] v);
        for (int i = 0; i < 1024; i++) rom[i] = v;
    endtask

    function automatic logic [15:0] sample_of(input int kind, input int k);
        case (kind)
            0: return (k < 1021) ? 16'h0040 : 16'h7FFF;
            1: return (k == 0) ? 16'h2000 : 16'h0000;
            2: return 16'h7FFF;
            3: return (k % 2 == 0) ? 16'h0020 : 16'hFFE0;
            4: return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic burst(input string tag, input int n, input int kind, input int gap,
                         input logic [15:0] exp_out, input logic exp_err);
        int addr_bad = 0;
        int early    = 0;
        int vld_at   = -1;
        int vld_cnt  = 0;
        logic [15:0] got_out = 16'hxxxx;
        logic        got_err = 1'bx;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            sequencing = 1'b1;
            smpl_in    = sample_of(kind, k);
            @(negedge clk);
            if (k < 1021 && coef_addr !== 10'(k + 1)) addr_bad++;
            if (vld !== 1'b0) early++;
        end
        for (int j = 0; j < gap; j++) begin
            @(posedge clk); #1;
            sequencing = 1'b0;
            smpl_in    = 16'h0000;
            @(negedge clk);
            if (vld === 1'b1) begin
                vld_cnt++;
                if (vld_at < 0) begin
                    vld_at  = j;
                    got_out = smpl_out;
                    got_err = len_err;
                end
            end
        end
        chk({tag, "_coef_addr_bad"}, 32'(addr_bad), 32'd0);
        chk({tag, "_vld_in_burst"}, 32'(early), 32'd0);
        chk({tag, "_vld_offset"}, 32'(vld_at), 32'd2);
        chk({tag, "_vld_count"}, 32'(vld_cnt), 32'd1);
        chk({tag, "_smpl_out"}, 32'(got_out), 32'(exp_out));
        chk({tag, "_len_err"}, 32'(got_err), 32'(exp_err));
    endtask

    initial begin
        int bad_vld;
        rst_n      = 1'b0;
        sequencing = 1'b0;
        smpl_in    = 16'h0000;
        set_rom(16'h0000);
        repeat (3) @(negedge clk);
        chk("rst_smpl_out", 32'(smpl_out), 32'h0);
        chk("rst_vld", 32'(vld), 32'h0);
        chk("rst_len_err", 32'(len_err), 32'h0);
        chk("rst_coef_addr", 32'(coef_addr), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        set_rom(16'h0000);
        rom[1] = 16'h4000;
        burst("impulse", 1021, 1, 6, 16'h1000, 1'b0);

        set_rom(16'h7FFF);
        burst("pos_ovf", 1021, 2, 6, EXP_POS_OVF, 1'b0);

        set_rom(16'h8000);
        burst("neg_ovf", 1021, 2, 6, EXP_NEG_OVF, 1'b0);

        set_rom(16'h4000);
        burst("short500", 500, 0, 6, 16'h3E80, 1'b1);
        burst("long1100", 1100, 0, 6, 16'h7FA0, 1'b1);
        burst("single_neg", 1, 4, 6, 16'hFFFF, 1'b1);

        // Reset in the middle of a burst, released while sequencing is still high.
        bad_vld = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            sequencing = 1'b1;
            smpl_in    = 16'h0040;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_smpl_out", 32'(smpl_out), 32'h0);
        chk("midrst_vld", 32'(vld), 32'h0);
        chk("midrst_coef_addr", 32'(coef_addr), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            sequencing = 1'b1;
            @(negedge clk);
            if (vld !== 1'b0) bad_vld++;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            sequencing = 1'b0;
            smpl_in    = 16'h0000;
            @(negedge clk);
            if (vld !== 1'b0) bad_vld++;
        end
        chk("midrst_no_vld", 32'(bad_vld), 32'd0);
        chk("midrst_out_held", 32'(smpl_out), 32'h0);
        burst("post_rst", 1021, 0, 6, 16'h7FA0, 1'b0);

        burst("b2b_a", 1021, 0, 3, 16'h7FA0, 1'b0);
        burst("b2b_b", 1021, 3, 6, 16'h0010, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
